// File: rtl/anton_neopixel_stream_decoder_pkg.sv
// Shared types and defaults for the NeoPixel stream decoder.
// Holds the decoder state encoding, timing defaults and counter widths.
package anton_neopixel_stream_decoder_pkg;

  typedef enum logic [1:0] {
    DEC_SYNC = 2'd0,
    DEC_IDLE = 2'd1,
    DEC_HIGH = 2'd2,
    DEC_LOW  = 2'd3
  } dec_state_t;

  // 320 ticks of 156.25 ns = 50 us, the WS2812 latch gap.
  localparam int BUFFER_END_DEFAULT     = 255;
  localparam int RESET_DELAY_DEFAULT    = 320;
  localparam int HIGH_THRESHOLD_DEFAULT = 4;
  localparam int MAX_HIGH_DEFAULT       = 7;

  localparam int HIGH_W     = 4;
  localparam int LOW_W      = 12;
  localparam int PIXEL_BITS = 24;

  // Width of a pixel index, never narrower than one bit.
  function automatic int index_bits(input int buffer_end);
    return (buffer_end < 1) ? 1 : $clog2(buffer_end + 1);
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_decoder_if.sv
// Pixel-side bus of the NeoPixel stream decoder.
// The decoder drives it through the master modport; the buffer side listens
// through the slave modport. No backpressure exists on this bus.
interface anton_neopixel_stream_decoder_if #(
  parameter int BUFFER_BITS = 8
);
  logic [23:0]            pixelData;
  logic                   pixelValid;
  logic [BUFFER_BITS-1:0] pixelIndex;
  logic                   frameDone;
  logic                   bitError;
  logic                   overflow;

  modport master (
    output pixelData, pixelValid, pixelIndex, frameDone, bitError, overflow
  );

  modport slave (
    input pixelData, pixelValid, pixelIndex, frameDone, bitError, overflow
  );
endinterface

// File: rtl/anton_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a
// clock domain. Reset clears both stages.
module anton_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_decoder.sv
// NeoPixel (WS2812-style) single-wire receive decoder.
// Measures high pulse widths on the synchronized line, assembles 24-bit
// pixels and detects the latch gap that ends a frame.
// Optional feature macro: ANTON_NEOPIXEL_DECODER_FORWARD_EN adds the
// streamForward daisy-chain output.
module anton_neopixel_stream_decoder
  import anton_neopixel_stream_decoder_pkg::*;
#(
  parameter int BUFFER_END     = BUFFER_END_DEFAULT,
  parameter int RESET_DELAY    = RESET_DELAY_DEFAULT,
  parameter int HIGH_THRESHOLD = HIGH_THRESHOLD_DEFAULT,
  parameter int MAX_HIGH       = MAX_HIGH_DEFAULT
) (
  input  logic                                   clk6_4mhz,
  input  logic                                   resetn,
  input  logic                                   streamInput,
  input  logic                                   enable,
  anton_neopixel_stream_decoder_if.master        pix,
  output logic [1:0]                             state
`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
  ,
  output logic                                   streamForward
`endif
);

  localparam int BUFFER_BITS = index_bits(BUFFER_END);
  localparam int PCOUNT_W    = $clog2(BUFFER_END + 2);

  localparam logic [PCOUNT_W-1:0] PIXEL_LAST = PCOUNT_W'(BUFFER_END);
  localparam logic [PCOUNT_W-1:0] PIXEL_SAT  = PCOUNT_W'(BUFFER_END + 1);
  localparam logic [HIGH_W-1:0]   THRESH_C   = HIGH_W'(HIGH_THRESHOLD);
  localparam logic [HIGH_W-1:0]   MAX_HIGH_C = HIGH_W'(MAX_HIGH);
  localparam logic [LOW_W-1:0]    GAP_C      = LOW_W'(RESET_DELAY);
  localparam logic [4:0]          BIT_LAST   = 5'(PIXEL_BITS - 1);

  function automatic logic [HIGH_W-1:0] sat_inc_high(input logic [HIGH_W-1:0] v);
    return (v == {HIGH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LOW_W-1:0] sat_inc_low(input logic [LOW_W-1:0] v);
    return (v == {LOW_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic                s;
  logic                s_prev;
  dec_state_t          cur;
  logic [HIGH_W-1:0]   high_count;
  logic [LOW_W-1:0]    low_count;
  logic [4:0]          bit_count;
  logic [PCOUNT_W-1:0] pixel_count;
  logic                got_bit;
  logic [23:0]         shifter;

  logic                rise;
  logic [HIGH_W-1:0]   high_next;
  logic [LOW_W-1:0]    low_next;
  logic                gap_done;
  logic                bit_val;
  logic [23:0]         shifted;
  logic                shift_en;
  logic                pixel_done;

  anton_sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk    (clk6_4mhz),
    .resetn (resetn),
    .d      (streamInput),
    .q      (s)
  );

  assign rise       = s & ~s_prev;
  assign high_next  = sat_inc_high(high_count);
  assign low_next   = sat_inc_low(low_count);
  assign gap_done   = (low_next >= GAP_C);
  assign bit_val    = (high_count >= THRESH_C);
  assign shifted    = {shifter[22:0], bit_val};
  // A fall while in HIGH is the moment a bit is decided.
  assign shift_en   = enable & (cur == DEC_HIGH) & ~s;
  assign pixel_done = shift_en & (bit_count == BIT_LAST);
  assign state      = cur;

  // Bit shifter: pure data, stale bits are pushed out by the next pixel.
  always_ff @(posedge clk6_4mhz) begin
    if (shift_en) begin
      shifter <= shifted;
    end
  end

  // Decoder FSM with registered strobes and pixel outputs.
  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      cur            <= DEC_SYNC;
      s_prev         <= 1'b0;
      high_count     <= '0;
      low_count      <= '0;
      bit_count      <= '0;
      pixel_count    <= '0;
      got_bit        <= 1'b0;
      pix.pixelData  <= '0;
      pix.pixelValid <= 1'b0;
      pix.pixelIndex <= '0;
      pix.frameDone  <= 1'b0;
      pix.bitError   <= 1'b0;
      pix.overflow   <= 1'b0;
    end else begin
      s_prev         <= s;
      pix.pixelValid <= 1'b0;
      pix.frameDone  <= 1'b0;
      pix.bitError   <= 1'b0;
      if (!enable) begin
        // Held like reset, but pixel outputs and overflow keep their values.
        cur         <= DEC_SYNC;
        high_count  <= '0;
        low_count   <= '0;
        bit_count   <= '0;
        pixel_count <= '0;
        got_bit     <= 1'b0;
      end else begin
        unique case (cur)
          DEC_SYNC: begin
            if (s) begin
              low_count <= '0;
            end else if (gap_done) begin
              // Clean start of a new frame after an error or reset.
              cur          <= DEC_IDLE;
              low_count    <= '0;
              bit_count    <= '0;
              pixel_count  <= '0;
              got_bit      <= 1'b0;
              pix.overflow <= 1'b0;
            end else begin
              low_count <= low_next;
            end
          end

          DEC_IDLE: begin
            if (rise) begin
              high_count <= HIGH_W'(1);
              cur        <= DEC_HIGH;
            end
          end

          DEC_HIGH: begin
            if (s) begin
              if (high_next > MAX_HIGH_C) begin
                // Pulse too long to be data: drop the partial pixel and resync.
                pix.bitError <= 1'b1;
                bit_count    <= '0;
                high_count   <= '0;
                low_count    <= '0;
                cur          <= DEC_SYNC;
              end else begin
                high_count <= high_next;
              end
            end else begin
              got_bit   <= 1'b1;
              low_count <= LOW_W'(1);
              cur       <= DEC_LOW;
              if (pixel_done) begin
                bit_count <= '0;
                if (pixel_count <= PIXEL_LAST) begin
                  pix.pixelData  <= shifted;
                  pix.pixelIndex <= pixel_count[BUFFER_BITS-1:0];
                  pix.pixelValid <= 1'b1;
                end else begin
                  pix.overflow <= 1'b1;
                end
                if (pixel_count != PIXEL_SAT) begin
                  pixel_count <= pixel_count + 1'b1;
                end
              end else begin
                bit_count <= bit_count + 5'd1;
              end
            end
          end

          DEC_LOW: begin
            if (rise) begin
              // A rise always wins over a gap completing in the same tick.
              high_count <= HIGH_W'(1);
              low_count  <= '0;
              cur        <= DEC_HIGH;
            end else if (gap_done) begin
              pix.frameDone <= got_bit;
              pix.bitError  <= (bit_count != 5'd0);
              pix.overflow  <= 1'b0;
              bit_count     <= '0;
              pixel_count   <= '0;
              got_bit       <= 1'b0;
              low_count     <= '0;
              cur           <= DEC_IDLE;
            end else begin
              low_count <= low_next;
            end
          end

          default: cur <= DEC_SYNC;
        endcase
      end
    end
  end

`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
  logic fwd_active;

  // Forward window opens once the locally consumed first pixel completes
  // and closes whenever the decoder is between frames or resyncing.
  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      fwd_active <= 1'b0;
    end else if (!enable || cur == DEC_IDLE || cur == DEC_SYNC) begin
      fwd_active <= 1'b0;
    end else if (pixel_done) begin
      fwd_active <= 1'b1;
    end
  end

  assign streamForward = fwd_active & s;
`endif

endmodule

// File: tb/tb_anton_neopixel_stream_decoder.sv
// Directed testbench for anton_neopixel_stream_decoder (BUFFER_END=3,
// shortened reset gap). Optional macro: ANTON_NEOPIXEL_DECODER_FORWARD_EN.
`timescale 1ns/1ps
module tb_anton_neopixel_stream_decoder;

  localparam int RD = 64;
  localparam int BE = 3;

  logic clk6_4mhz = 1'b0;
  logic resetn;
  logic streamInput;
  logic enable;
  logic [1:0] state;
`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
  logic streamForward;
`endif

  anton_neopixel_stream_decoder_if #(.BUFFER_BITS(2)) pix_if ();

  anton_neopixel_stream_decoder #(
    .BUFFER_END  (BE),
    .RESET_DELAY (RD)
  ) dut (
    .clk6_4mhz   (clk6_4mhz),
    .resetn      (resetn),
    .streamInput (streamInput),
    .enable      (enable),
    .pix         (pix_if),
    .state       (state)
`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
    ,
    .streamForward (streamForward)
`endif
  );

  always #78.125 clk6_4mhz = ~clk6_4mhz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int be_cnt = 0;
  int last_fall = 0;
  int fwd_mode = 0;
  int fwd_bad = 0;
  int fwd_ones = 0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  logic [31:0] pv_data[$];
  logic [31:0] pv_idx[$];
  int          pv_cyc[$];
  int pv_base, fd_base, be_base, fall0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_at(input int i);
    if (i < pv_data.size()) return pv_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] idx_at(input int i);
    if (i < pv_idx.size()) return pv_idx[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Cycle counter and a bench copy of the 2-flop input delay.
  always @(posedge clk6_4mhz) begin
    cyc <= cyc + 1;
    d1  <= streamInput;
    d2  <= d1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk6_4mhz) begin
    if (pix_if.pixelValid === 1'b1) begin
      pv_data.push_back(32'(pix_if.pixelData));
      pv_idx.push_back(32'(pix_if.pixelIndex));
      pv_cyc.push_back(cyc);
    end
    if (pix_if.frameDone === 1'b1) fd_cnt <= fd_cnt + 1;
    if (pix_if.bitError === 1'b1) be_cnt <= be_cnt + 1;
`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
    if (fwd_mode == 1 && streamForward !== 1'b0) fwd_bad <= fwd_bad + 1;
    if (fwd_mode == 2 && streamForward !== d2) fwd_bad <= fwd_bad + 1;
    if (fwd_mode == 2 && streamForward === 1'b1) fwd_ones <= fwd_ones + 1;
`endif
  end

  task automatic mark();
    pv_base = pv_data.size();
    fd_base = fd_cnt;
    be_base = be_cnt;
  endtask

  // Entered and left on a falling clock edge.
  task automatic send_pulse(input int hi, input int lo);
    streamInput = 1'b1;
    repeat (hi) @(negedge clk6_4mhz);
    streamInput = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk6_4mhz);
  endtask

  task automatic send_pixel_t(input logic [23:0] p, input int h1, input int l1,
                              input int h0, input int l0, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (p[i]) send_pulse(h1, l1);
      else      send_pulse(h0, l0);
    end
  endtask

  task automatic send_pixel(input logic [23:0] p);
    send_pixel_t(p, 5, 3, 2, 6, 24);
  endtask

  task automatic gap();
    streamInput = 1'b0;
    repeat (RD + 10) @(negedge clk6_4mhz);
  endtask

  task automatic check_counts(input string tag, input int npix, input int nfd, input int nbe);
    check_val({tag, "_pixels"}, 32'(pv_data.size() - pv_base), 32'(npix));
    check_val({tag, "_frameDone"}, 32'(fd_cnt - fd_base), 32'(nfd));
    check_val({tag, "_bitError"}, 32'(be_cnt - be_base), 32'(nbe));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    streamInput = 1'b0;
    enable = 1'b1;
    #400;
    check_val("rst_pixelData", 32'(pix_if.pixelData), 32'h0);
    check_val("rst_pixelIndex", 32'(pix_if.pixelIndex), 32'h0);
    check_val("rst_strobes", {29'b0, pix_if.pixelValid, pix_if.frameDone, pix_if.bitError}, 32'h0);
    check_val("rst_overflow", 32'(pix_if.overflow), 32'h0);
    check_val("rst_state", 32'(state), 32'h0);
    @(negedge clk6_4mhz);
    resetn = 1'b1;
    gap();
    check_val("s1_state_idle", 32'(state), 32'h1);

    // Two pixels, standard timing; forward window opens after pixel 0.
    mark();
    fwd_mode = 1;
    send_pixel(24'hFF0000);
    fall0 = last_fall;
    fwd_mode = 2;
    send_pixel(24'h00A55A);
    gap();
    fwd_mode = 0;
    check_counts("s1", 2, 1, 0);
    check_val("s1_data0", data_at(pv_base), 32'hFF0000);
    check_val("s1_idx0", idx_at(pv_base), 32'h0);
    check_val("s1_data1", data_at(pv_base + 1), 32'h00A55A);
    check_val("s1_idx1", idx_at(pv_base + 1), 32'h1);
    check_val("s1_latency", 32'((pv_base < pv_cyc.size()) ? pv_cyc[pv_base] - fall0 : -1), 32'd3);
`ifdef ANTON_NEOPIXEL_DECODER_FORWARD_EN
    check_val("s1_fwd_mismatches", 32'(fwd_bad), 32'h0);
    check_val("s1_fwd_active", 32'(fwd_ones > 0), 32'h1);
`endif

    // Threshold and maximum-width boundaries: 4/3 ticks, then 7/1 ticks.
    mark();
    send_pixel_t(24'h5A0FF0, 4, 4, 3, 5, 24);
    send_pixel_t(24'hC33C81, 7, 1, 1, 7, 24);
    gap();
    check_counts("s2", 2, 1, 0);
    check_val("s2_thresh_data", data_at(pv_base), 32'h5A0FF0);
    check_val("s2_maxhigh_data", data_at(pv_base + 1), 32'hC33C81);

    // 8-tick pulse mid-pixel: error, rest ignored until the gap.
    mark();
    send_pixel_t(24'hFFFFFF, 5, 3, 2, 6, 10);
    send_pulse(8, 4);
    send_pixel_t(24'hAAAAAA, 5, 3, 2, 6, 20);
    gap();
    check_counts("s3_err", 0, 0, 1);
    mark();
    send_pixel(24'h123456);
    gap();
    check_counts("s3_clean", 1, 1, 0);
    check_val("s3_data", data_at(pv_base), 32'h123456);
    check_val("s3_idx", idx_at(pv_base), 32'h0);

    // Truncated frame of 10 bits.
    mark();
    send_pixel_t(24'hF0F0F0, 5, 3, 2, 6, 10);
    gap();
    check_counts("s4", 0, 1, 1);

    // Six pixels into a four-entry buffer.
    mark();
    for (int k = 0; k < 6; k++) begin
      send_pixel(24'h111111 * (k + 1));
      if (k == 3) check_val("s5_ovf_after_p3", 32'(pix_if.overflow), 32'h0);
      if (k == 4) check_val("s5_ovf_after_p4", 32'(pix_if.overflow), 32'h1);
    end
    gap();
    check_counts("s5", 4, 1, 0);
    check_val("s5_ovf_cleared", 32'(pix_if.overflow), 32'h0);
    check_val("s5_data3", data_at(pv_base + 3), 32'h444444);
    check_val("s5_idx3", idx_at(pv_base + 3), 32'h3);
    check_val("s5_idx0", idx_at(pv_base), 32'h0);

    // Disable: state forced to SYNC, pixel outputs held.
    enable = 1'b0;
    repeat (3) @(negedge clk6_4mhz);
    check_val("en0_state", 32'(state), 32'h0);
    check_val("en0_hold_data", 32'(pix_if.pixelData), 32'h444444);
    enable = 1'b1;
    gap();

    // Reset during bit 12 of a pixel past the buffer end.
    for (int k = 0; k < 5; k++) send_pixel(24'h0F0F0F + 24'(k));
    send_pixel_t(24'hFFFFFF, 5, 3, 2, 6, 11);
    streamInput = 1'b1;
    repeat (2) @(negedge clk6_4mhz);
    #10 resetn = 1'b0;
    #1;
    check_val("mr_pixelData", 32'(pix_if.pixelData), 32'h0);
    check_val("mr_overflow", 32'(pix_if.overflow), 32'h0);
    check_val("mr_state", 32'(state), 32'h0);
    @(negedge clk6_4mhz);
    streamInput = 1'b0;
    #10 resetn = 1'b1;
    @(negedge clk6_4mhz);
    mark();
    send_pixel(24'h777777);
    gap();
    check_counts("mr_nogap", 0, 0, 0);
    mark();
    send_pixel(24'h13579B);
    gap();
    check_counts("mr_resume", 1, 1, 0);
    check_val("mr_resume_data", data_at(pv_base), 32'h13579B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
